// File: rtl/tilelink_pkg.sv
// Shared TileLink-UL definitions: A/D opcodes, initiator state encoding, and
// the helper that gives the number of D beats a request of a given size produces.
package tilelink_pkg;

  localparam logic [2:0] A_PUTFULL    = 3'd0;
  localparam logic [2:0] A_PUTPARTIAL = 3'd1;
  localparam logic [2:0] A_GET        = 3'd4;

  localparam logic [2:0] D_ACCESSACK     = 3'd0;
  localparam logic [2:0] D_ACCESSACKDATA = 3'd1;
  localparam logic [2:0] D_HINTACK       = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_D
  } state_t;

  // A transfer smaller than the bus still takes one beat.
  function automatic logic [10:0] beats(input logic [3:0] size, input int unsigned xlen_bytes);
    int unsigned n;
    n = (32'd1 << size) / xlen_bytes;
    if (n == 0) n = 1;
    return 11'(n);
  endfunction

endpackage

// File: rtl/tilelink_mask_gen.sv
// Byte-lane mask for a naturally aligned transfer of 2^size bytes at the given
// bus offset; transfers of bus width or larger enable every lane.
module tilelink_mask_gen #(
  parameter int BYTES = 4
) (
  input  logic [3:0]               i_size,
  input  logic [$clog2(BYTES)-1:0] i_offset,
  output logic [BYTES-1:0]         o_mask
);

  localparam int LG = $clog2(BYTES);

  always_comb begin
    o_mask = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (i_size >= 4'(LG)) o_mask[i] = 1'b1;
      else                  o_mask[i] = ((LG'(i) >> i_size) == (i_offset >> i_size));
    end
  end

endmodule

// File: rtl/tilelink_ad_initiator.sv
// TL-UL A/D initiator: one outstanding Get/Put, D-channel protocol checking.
// Optional D-wait watchdog enabled by defining TL_TIMEOUT_EN.
//
// state     | meaning
// ST_IDLE   | cmd_ready high, accepting a command (illegal ones answered locally)
// ST_REQ    | A beat presented, held stable until a_ready
// ST_WAIT_D | d_ready high, collecting response beats
module tilelink_ad_initiator
  import tilelink_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ADDR_W    = 32,
  parameter int SOURCE_W  = 5,
  parameter int SOURCE_ID = 0,
  parameter int TIMEOUT   = 1024
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_opcode,
  input  logic [3:0]            cmd_size,
  input  logic [ADDR_W-1:0]     cmd_address,
  input  logic [XLEN/8-1:0]     cmd_mask,
  input  logic [XLEN-1:0]       cmd_data,
  input  logic                  a_ready,
  output logic                  a_valid,
  output logic [2:0]            a_bits_opcode,
  output logic [2:0]            a_bits_param,
  output logic [3:0]            a_bits_size,
  output logic [SOURCE_W-1:0]   a_bits_source,
  output logic [ADDR_W-1:0]     a_bits_address,
  output logic [XLEN/8-1:0]     a_bits_mask,
  output logic [XLEN-1:0]       a_bits_data,
  output logic                  d_ready,
  input  logic                  d_valid,
  input  logic [2:0]            d_bits_opcode,
  input  logic [1:0]            d_bits_param,
  input  logic [3:0]            d_bits_size,
  input  logic [SOURCE_W-1:0]   d_bits_source,
  input  logic                  d_bits_sink,
  input  logic [XLEN-1:0]       d_bits_data,
  input  logic                  d_bits_error,
  output logic                  rsp_valid,
  output logic [XLEN-1:0]       rsp_data,
  output logic                  rsp_error,
  output logic                  rsp_last,
  output logic                  proto_err
);

  localparam int XLEN_BYTES = XLEN / 8;
  localparam int LG_BYTES   = $clog2(XLEN_BYTES);
  // A 4 KiB Get on a 32-bit bus needs 1024 beats, one more bit than at 64-bit.
  localparam int BEAT_W     = (XLEN == 32) ? 10 : 9;

  state_t                r_state;
  logic                  r_cmd_ready, r_a_valid, r_d_ready;
  logic [2:0]            r_op;
  logic [3:0]            r_size;
  logic [ADDR_W-1:0]     r_addr;
  logic [XLEN_BYTES-1:0] r_mask;
  logic [XLEN-1:0]       r_data;
  logic [BEAT_W-1:0]     r_beat;
  logic                  r_rsp_valid, r_rsp_error, r_rsp_last, r_proto_err;
  logic [XLEN-1:0]       r_rsp_data;

  logic                  w_legal, w_is_get, w_last, w_bad_beat;
  logic [XLEN_BYTES-1:0] w_size_mask;
  logic [BEAT_W-1:0]     w_last_idx;
  logic                  w_unused_inputs;

`ifdef TL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] r_wdog;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  tilelink_mask_gen #(.BYTES(XLEN_BYTES)) u_mask_gen (
    .i_size   (r_size),
    .i_offset (r_addr[LG_BYTES-1:0]),
    .o_mask   (w_size_mask)
  );

  always_comb begin
    w_legal = 1'b0;
    case (cmd_opcode)
      A_GET:                   w_legal = (cmd_size <= 4'd12);
      A_PUTFULL, A_PUTPARTIAL: w_legal = (cmd_size <= 4'(LG_BYTES));
      default:                 w_legal = 1'b0;
    endcase
  end

  assign w_is_get        = (r_op == A_GET);
  assign w_last_idx      = w_is_get ? BEAT_W'(beats(r_size, XLEN_BYTES) - 11'd1) : '0;
  assign w_last          = (r_beat == w_last_idx);
  assign w_bad_beat      = (d_bits_opcode != (w_is_get ? D_ACCESSACKDATA : D_ACCESSACK))
                        || (d_bits_source != SOURCE_W'(SOURCE_ID))
                        || (d_bits_size != r_size);
  assign w_unused_inputs = ^{d_bits_param, d_bits_sink};

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_a_valid   <= 1'b0;
      r_d_ready   <= 1'b0;
      r_op        <= A_PUTFULL;
      r_size      <= '0;
      r_addr      <= '0;
      r_mask      <= '0;
      r_data      <= '0;
      r_beat      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_rsp_data  <= '0;
      r_proto_err <= 1'b0;
`ifdef TL_TIMEOUT_EN
      r_wdog      <= '0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_last  <= 1'b0;
      if (d_valid && r_state != ST_WAIT_D) r_proto_err <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (r_cmd_ready && cmd_valid) begin
            r_op   <= cmd_opcode;
            r_size <= cmd_size;
            r_addr <= cmd_address;
            r_mask <= cmd_mask;
            r_data <= cmd_data;
            if (w_legal) begin
              r_state     <= ST_REQ;
              r_cmd_ready <= 1'b0;
              r_a_valid   <= 1'b1;
            end else begin
              r_rsp_valid <= 1'b1;
              r_rsp_error <= 1'b1;
              r_rsp_last  <= 1'b1;
              r_rsp_data  <= '0;
            end
          end
        end

        ST_REQ: begin
          if (a_ready) begin
            r_state   <= ST_WAIT_D;
            r_a_valid <= 1'b0;
            r_d_ready <= 1'b1;
            r_beat    <= '0;
`ifdef TL_TIMEOUT_EN
            r_wdog    <= '0;
`endif
          end
        end

        ST_WAIT_D: begin
          if (d_valid) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_is_get ? d_bits_data : '0;
            r_rsp_error <= d_bits_error;
            r_rsp_last  <= w_last;
            r_beat      <= r_beat + 1'b1;
            if (w_bad_beat) r_proto_err <= 1'b1;
            if (w_last) begin
              r_state     <= ST_IDLE;
              r_d_ready   <= 1'b0;
              r_cmd_ready <= 1'b1;
            end
`ifdef TL_TIMEOUT_EN
            r_wdog <= '0;
          end else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
            r_rsp_valid <= 1'b1;
            r_rsp_error <= 1'b1;
            r_rsp_last  <= 1'b1;
            r_rsp_data  <= '0;
            r_proto_err <= 1'b1;
            r_state     <= ST_IDLE;
            r_d_ready   <= 1'b0;
            r_cmd_ready <= 1'b1;
          end else begin
            r_wdog <= r_wdog + 1'b1;
`endif
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready      = r_cmd_ready;
  assign a_valid        = r_a_valid;
  assign a_bits_opcode  = r_op;
  assign a_bits_param   = 3'd0;
  assign a_bits_size    = r_size;
  assign a_bits_source  = SOURCE_W'(SOURCE_ID);
  assign a_bits_address = r_addr;
  assign a_bits_mask    = (r_op == A_PUTPARTIAL) ? r_mask : w_size_mask;
  assign a_bits_data    = r_data;
  assign d_ready        = r_d_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_data       = r_rsp_data;
  assign rsp_error      = r_rsp_error;
  assign rsp_last       = r_rsp_last;
  assign proto_err      = r_proto_err;

endmodule
